// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: access size
// encodings, controller state encoding and size helper.
package mem_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_PULSE = 3'd2,
        ST_WR_HOLD  = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    // Number of bytes touched by an access of the given size encoding.
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        logic [3:0] n;
        case (size)
            SZ_BYTE:  n = 4'd1;
            SZ_HALF:  n = 4'd2;
            SZ_WORD:  n = 4'd4;
            SZ_DWORD: n = 4'd8;
            default:  n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Byte-lane helper for the access controller. Pure combinational logic:
//  - load path: keeps the low (1 << size) bytes of the memory doubleword and
//    sign- or zero-extends them to 64 bits;
//  - store path: overlays the low (1 << size) bytes of the new data onto the
//    old doubleword so the untouched neighbouring bytes are written back.
module mem_lane_merge
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [63:0] old_data,
    input  logic [63:0] new_data,
    output logic [63:0] load_data,
    output logic [63:0] store_data
);

    // Extract the addressed low bytes and extend them to a full doubleword.
    always_comb begin
        load_data = 64'd0;
        case (size)
            SZ_BYTE:  load_data = {{56{sign_ext & old_data[7]}},  old_data[7:0]};
            SZ_HALF:  load_data = {{48{sign_ext & old_data[15]}}, old_data[15:0]};
            SZ_WORD:  load_data = {{32{sign_ext & old_data[31]}}, old_data[31:0]};
            SZ_DWORD: load_data = old_data;
            default:  load_data = old_data;
        endcase
    end

    // Overlay the store bytes on the previously read doubleword.
    always_comb begin
        store_data = old_data;
        case (size)
            SZ_BYTE:  store_data = {old_data[63:8],  new_data[7:0]};
            SZ_HALF:  store_data = {old_data[63:16], new_data[15:0]};
            SZ_WORD:  store_data = {old_data[63:32], new_data[31:0]};
            SZ_DWORD: store_data = new_data;
            default:  store_data = new_data;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for the byte-addressed little-endian data memory.
// Takes one load/store at a time over a valid/ready handshake, drives the
// memory pins with registered outputs, waits the fixed memory latencies and
// returns one response pulse per accepted request. Stores narrower than a
// doubleword are performed as read-modify-write of the 8-byte window.
//
// Build option: define MEM_ALIGN_CHECK_EN to also fault requests whose
// address is not a multiple of the access size. Without it any alignment is
// legal and only the range check applies.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int MEM_BYTES = 128,
    parameter int RD_LAT    = 1,
    parameter int WR_LAT    = 8
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_fault,
    output logic [63:0] mem_address,
    output logic [63:0] mem_data_in,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [63:0] mem_data_out
);

    // Highest start address whose full 8-byte window still fits in memory.
    localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);
    localparam logic [15:0] RD_LAST  = 16'(RD_LAT - 1);
    localparam logic [15:0] WR_LAST  = 16'(WR_LAT - 1);

    state_t      state_r;
    logic [15:0] cnt_r;
    logic        write_r;
    logic [1:0]  size_r;
    logic        sign_r;
    logic [63:0] wdata_r;

    logic        req_ready_r;
    logic        resp_valid_r;
    logic [63:0] resp_rdata_r;
    logic        resp_fault_r;
    logic [63:0] mem_address_r;
    logic [63:0] mem_data_in_r;
    logic        mem_read_r;
    logic        mem_write_r;

    logic        range_fault_s;
    logic        align_fault_s;
    logic        fault_s;
    logic [63:0] load_data_s;
    logic [63:0] store_data_s;

    // Decide whether the request currently offered must be rejected.
    always_comb begin
        range_fault_s = (req_addr > ADDR_MAX);
`ifdef MEM_ALIGN_CHECK_EN
        align_fault_s = ((req_addr[3:0] & (size_bytes(req_size) - 4'd1)) != 4'd0);
`else
        align_fault_s = 1'b0;
`endif
        fault_s = range_fault_s | align_fault_s;
    end

    // Lane handling works straight off the memory output in the capture
    // cycle; the registered results below act as the captured data.
    mem_lane_merge u_lane_merge (
        .size       (size_r),
        .sign_ext   (sign_r),
        .old_data   (mem_data_out),
        .new_data   (wdata_r),
        .load_data  (load_data_s),
        .store_data (store_data_s)
    );

    // Controller FSM: sequences the memory pins and produces the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 16'd0;
            write_r       <= 1'b0;
            size_r        <= SZ_BYTE;
            sign_r        <= 1'b0;
            wdata_r       <= 64'd0;
            req_ready_r   <= 1'b1;
            resp_valid_r  <= 1'b0;
            resp_rdata_r  <= 64'd0;
            resp_fault_r  <= 1'b0;
            mem_address_r <= 64'd0;
            mem_data_in_r <= 64'd0;
            mem_read_r    <= 1'b0;
            mem_write_r   <= 1'b0;
        end else begin
            resp_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_r     <= req_write;
                        size_r      <= req_size;
                        sign_r      <= req_signed;
                        wdata_r     <= req_wdata;
                        cnt_r       <= 16'd0;
                        req_ready_r <= 1'b0;
                        if (fault_s) begin
                            // Rejected: no memory access at all.
                            state_r      <= ST_RESP;
                            resp_valid_r <= 1'b1;
                            resp_fault_r <= 1'b1;
                            resp_rdata_r <= 64'd0;
                        end else if (req_write && (req_size == SZ_DWORD)) begin
                            // Full-window store needs no read-back.
                            state_r       <= ST_WR_PULSE;
                            mem_address_r <= req_addr;
                            mem_data_in_r <= req_wdata;
                            mem_write_r   <= 1'b1;
                        end else begin
                            state_r       <= ST_RD;
                            mem_address_r <= req_addr;
                            mem_read_r    <= 1'b1;
                        end
                    end else begin
                        state_r     <= ST_IDLE;
                        req_ready_r <= 1'b1;
                    end
                end
                ST_RD: begin
                    if (cnt_r == RD_LAST) begin
                        cnt_r      <= 16'd0;
                        mem_read_r <= 1'b0;
                        if (write_r) begin
                            state_r       <= ST_WR_PULSE;
                            mem_data_in_r <= store_data_s;
                            mem_write_r   <= 1'b1;
                        end else begin
                            state_r       <= ST_RESP;
                            mem_address_r <= 64'd0;
                            resp_valid_r  <= 1'b1;
                            resp_fault_r  <= 1'b0;
                            resp_rdata_r  <= load_data_s;
                        end
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_WR_PULSE: begin
                    // The write strobe is a single cycle; address/data stay put.
                    state_r     <= ST_WR_HOLD;
                    mem_write_r <= 1'b0;
                    cnt_r       <= 16'd0;
                end
                ST_WR_HOLD: begin
                    if (cnt_r == WR_LAST) begin
                        state_r       <= ST_RESP;
                        cnt_r         <= 16'd0;
                        mem_address_r <= 64'd0;
                        mem_data_in_r <= 64'd0;
                        resp_valid_r  <= 1'b1;
                        resp_fault_r  <= 1'b0;
                        resp_rdata_r  <= 64'd0;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_RESP: begin
                    state_r      <= ST_IDLE;
                    req_ready_r  <= 1'b1;
                    resp_rdata_r <= 64'd0;
                    resp_fault_r <= 1'b0;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    cnt_r         <= 16'd0;
                    req_ready_r   <= 1'b1;
                    resp_rdata_r  <= 64'd0;
                    resp_fault_r  <= 1'b0;
                    mem_address_r <= 64'd0;
                    mem_data_in_r <= 64'd0;
                    mem_read_r    <= 1'b0;
                    mem_write_r   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_r;
    assign resp_valid  = resp_valid_r;
    assign resp_rdata  = resp_rdata_r;
    assign resp_fault  = resp_fault_r;
    assign mem_address = mem_address_r;
    assign mem_data_in = mem_data_in_r;
    assign mem_read    = mem_read_r;
    assign mem_write   = mem_write_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: behavioural memory preloaded with
// byte[i] = i, a reference byte array for expected load data, and a queue of
// expected responses popped when resp_valid is seen.
module tb_mem_access_ctrl;

    localparam int MEM_BYTES = 128;
    localparam int RD_LAT    = 1;
    localparam int WR_LAT    = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_fault;
    logic [63:0] mem_address;
    logic [63:0] mem_data_in;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_data_out;

    logic [7:0] mem     [0:MEM_BYTES-1];
    logic [7:0] ref_mem [0:MEM_BYTES-1];
    logic       preload;

    typedef struct {
        logic [63:0] rdata;
        logic        fault;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    int   rd_cycles = 0;
    int   wr_cycles = 0;
    int   conflict_cnt = 0;

    mem_access_ctrl #(
        .MEM_BYTES (MEM_BYTES),
        .RD_LAT    (RD_LAT),
        .WR_LAT    (WR_LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    // Edge counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Memory read port: valid while mem_read is high.
    always_comb begin
        mem_data_out = 64'd0;
        if (mem_read && (mem_address <= 64'(MEM_BYTES - 8))) begin
            for (int i = 0; i < 8; i++) mem_data_out[8*i +: 8] = mem[int'(mem_address) + i];
        end
    end

    // Memory write port and initial preload.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'(i);
        end else if (mem_write && (mem_address <= 64'(MEM_BYTES - 8))) begin
            for (int i = 0; i < 8; i++) mem[int'(mem_address) + i] <= mem_data_in[8*i +: 8];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] expected);
        n_checks++;
        if (got !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, expected);
        end
    endtask

    // Response monitor and memory-pin activity counters.
    always @(negedge clk) begin
        if (mem_read)              rd_cycles    <= rd_cycles + 1;
        if (mem_write)             wr_cycles    <= wr_cycles + 1;
        if (mem_read && mem_write) conflict_cnt <= conflict_cnt + 1;
        if (resp_valid) begin
            check_eq("resp_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check_eq("resp_rdata", resp_rdata, mon_e.rdata);
                check_eq("resp_fault", 64'(resp_fault), 64'(mon_e.fault));
                check_eq("resp_latency", 64'(cyc - accept_cyc + 1), 64'(mon_e.lat));
            end
        end
    end

    function automatic logic [63:0] model_load(input logic [63:0] addr, input logic [1:0] sz, input logic sg);
        logic [63:0] v;
        int          n;
        v = 64'd0;
        n = 1 << sz;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(addr) + i];
        if (sg && (n < 8) && v[8*n-1]) begin
            for (int i = 8 * n; i < 64; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Issue one request from IDLE, queue its expectation and wait for it.
    task automatic do_req(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [63:0] addr, input logic [63:0] wd,
                          input logic [63:0] exp_rd, input logic exp_f);
        exp_t e;
        int   rd0, wr0, exp_rdc, exp_wrc, guard, n;
        e.rdata = exp_rd;
        e.fault = exp_f;
        if (exp_f)                 e.lat = 1;
        else if (!wr)              e.lat = RD_LAT + 1;
        else if (sz == 2'd3)       e.lat = WR_LAT + 2;
        else                       e.lat = RD_LAT + WR_LAT + 2;
        exp_rdc = (exp_f || (wr && (sz == 2'd3))) ? 0 : RD_LAT;
        exp_wrc = (!exp_f && wr) ? 1 : 0;

        check_eq({tag, "_idle_ready"}, 64'(req_ready), 64'd1);
        check_eq({tag, "_idle_addr"}, mem_address | mem_data_in, 64'd0);
        check_eq({tag, "_idle_rw"}, 64'({mem_read, mem_write}), 64'd0);

        exp_q.push_back(e);
        rd0 = rd_cycles;
        wr0 = wr_cycles;
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        // Keep a different request on the bus while busy: it must be ignored.
        req_write  = ~wr;
        req_size   = ~sz;
        req_signed = ~sg;
        req_addr   = 64'd8;
        req_wdata  = ~wd;
        check_eq({tag, "_busy_ready"}, 64'(req_ready), 64'd0);

        guard = 0;
        while ((exp_q.size() != 0) && (guard < 200)) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b0;
        check_eq({tag, "_resp_seen"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        check_eq({tag, "_read_cycles"}, 64'(rd_cycles - rd0), 64'(exp_rdc));
        check_eq({tag, "_write_pulses"}, 64'(wr_cycles - wr0), 64'(exp_wrc));
        req_write  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 64'd0;
        req_wdata  = 64'd0;

        if (wr && !exp_f) begin
            n = 1 << sz;
            for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
        end
    endtask

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ra, rw;
        logic [1:0]  rs;
        logic        rwr, rsg;
        logic        misalign_fault;

        rst_n      = 1'b0;
        preload    = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 64'd0;
        req_wdata  = 64'd0;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'(i);

        repeat (3) @(posedge clk);
        #1;
        preload = 1'b0;
        check_eq("rst_ready", 64'(req_ready), 64'd1);
        check_eq("rst_resp", 64'({resp_valid, resp_fault}) | resp_rdata, 64'd0);
        check_eq("rst_mem", mem_address | mem_data_in | 64'({mem_read, mem_write}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_req("ld_d0",    1'b0, 2'd3, 1'b0, 64'd0,  64'd0, 64'h0706050403020100, 1'b0);
        do_req("st_h16",   1'b1, 2'd1, 1'b0, 64'd16, 64'h1234_5678_9ABC_BEEF, 64'd0, 1'b0);
        do_req("ld_d16",   1'b0, 2'd3, 1'b0, 64'd16, 64'd0, 64'h1716151413_12BEEF, 1'b0);
        for (int i = 18; i < 24; i++) check_eq("mem_neighbour", 64'(mem[i]), 64'(i));
        do_req("st_b40",   1'b1, 2'd0, 1'b0, 64'd40, 64'hDEAD_BEEF_CAFE_1280, 64'd0, 1'b0);
        do_req("ld_sb40",  1'b0, 2'd0, 1'b1, 64'd40, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        do_req("ld_ub40",  1'b0, 2'd0, 1'b0, 64'd40, 64'd0, 64'h0000_0000_0000_0080, 1'b0);
        do_req("ld_d121",  1'b0, 2'd3, 1'b0, 64'd121, 64'd0, 64'd0, 1'b1);
        do_req("ld_dneg",  1'b0, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd0, 1'b1);
        do_req("ld_b127",  1'b0, 2'd0, 1'b0, 64'd127, 64'd0, 64'd0, 1'b1);
        do_req("st_dneg",  1'b1, 2'd3, 1'b0, 64'd124, 64'h5555_5555_5555_5555, 64'd0, 1'b1);
        do_req("ld_d120",  1'b0, 2'd3, 1'b0, 64'd120, 64'd0, 64'h7F7E7D7C7B7A7978, 1'b0);
        do_req("st_d56",   1'b1, 2'd3, 1'b0, 64'd56, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0);
        do_req("ld_d56",   1'b0, 2'd3, 1'b0, 64'd56, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0);
        do_req("ld_sh56",  1'b0, 2'd1, 1'b1, 64'd56, 64'd0, 64'hFFFF_FFFF_FFFF_CDEF, 1'b0);
        do_req("ld_sw60",  1'b0, 2'd2, 1'b1, 64'd60, 64'd0, 64'h0000_0000_0123_4567, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
        misalign_fault = 1'b1;
        do_req("ld_h3",    1'b0, 2'd1, 1'b0, 64'd3, 64'd0, 64'd0, 1'b1);
`else
        misalign_fault = 1'b0;
        do_req("ld_h3",    1'b0, 2'd1, 1'b0, 64'd3, 64'd0, 64'h0000_0000_0000_0403, 1'b0);
`endif

        // Reset while the dword store at 48 is in its hold phase.
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_size   = 2'd3;
        req_addr   = 64'd48;
        req_wdata  = 64'hA5A5_A5A5_A5A5_A5A5;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("hold_addr", mem_address, 64'd48);
        check_eq("hold_write", 64'(mem_write), 64'd0);
        rst_n = 1'b0;
        #1;
        check_eq("arst_ready", 64'(req_ready), 64'd1);
        check_eq("arst_resp", 64'({resp_valid, resp_fault}) | resp_rdata, 64'd0);
        check_eq("arst_mem", mem_address | mem_data_in | 64'({mem_read, mem_write}), 64'd0);
        req_write = 1'b0;
        req_size  = 2'd0;
        req_addr  = 64'd0;
        req_wdata = 64'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_req("ld_d0_post_rst", 1'b0, 2'd3, 1'b0, 64'd0, 64'd0, 64'h0706050403020100, 1'b0);

        // Mixed random traffic in the upper region, checked against the model.
        for (int k = 0; k < 16; k++) begin
            rwr = 1'($urandom_range(0, 1));
            rsg = 1'($urandom_range(0, 1));
            rs  = 2'($urandom_range(0, 3));
            ra  = 64'($urandom_range(64, 120));
            if (misalign_fault) ra = ra & ~(64'(1 << rs) - 64'd1);
            rw  = {$urandom(), $urandom()};
            if (rwr) do_req("rnd_st", 1'b1, rs, rsg, ra, rw, 64'd0, 1'b0);
            else     do_req("rnd_ld", 1'b0, rs, rsg, ra, 64'd0, model_load(ra, rs, rsg), 1'b0);
        end
        do_req("rnd_verify", 1'b0, 2'd3, 1'b0, 64'd88, 64'd0, model_load(64'd88, 2'd3, 1'b0), 1'b0);

        check_eq("rd_wr_exclusive", 64'(conflict_cnt), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator-side controller for the byte-addressed little-endian data memory.
- Accepts single load/store requests from the datapath over a valid/ready handshake.
- Drives the memory's address, data_in, read and write pins, waits the memory's fixed latency, and returns sized, sign/zero-extended load data.
- Sub-doubleword stores are done as read-modify-write, so neighbouring bytes in the 8-byte window are preserved.

Parameters:
- MEM_BYTES, 128: memory capacity in bytes; upper bound for the legal address range.
- RD_LAT, 1: cycles from mem_read assertion to the cycle in which mem_data_out is valid and captured; minimum 1.
- WR_LAT, 8: cycles address/data are held stable after the write pulse, until the write is complete; minimum 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- req_valid  in  1  request present
- req_ready  out  1  controller idle; request accepted when req_valid & req_ready at posedge
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword
- req_signed  in  1  sign-extend load result
- req_addr  in  64  byte address
- req_wdata  in  64  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  64  extended load data; 0 for stores and faults
- resp_fault  out  1  request rejected; no memory access made
- mem_address  out  64  to memory address
- mem_data_in  out  64  to memory data_in
- mem_read  out  1  to memory read
- mem_write  out  1  to memory write
- mem_data_out  in  64  from memory data_out

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state IDLE, req_ready 1, every other output 0, counters 0.
- Reset mid-operation: abort immediately, no response issued; memory contents after an interrupted store are undefined.
- States: IDLE, RD, WR_PULSE, WR_HOLD, RESP.
- IDLE:
  - req_ready = 1.
  - On accept, latch write, size, signed, addr and wdata.
  - Fault when addr > MEM_BYTES-8. The full 8-byte window must fit, for all sizes.
  - Fault -> RESP with fault = 1.
  - Load, or store with size != 3 -> RD.
  - Store with size == 3 -> WR_PULSE, with mem_data_in = wdata.
- RD:
  - mem_read = 1, mem_address = addr, count RD_LAT cycles.
  - On the last cycle, capture mem_data_out into the data register and drop mem_read.
  - Load -> RESP with rdata = low (1 << size) bytes of the captured data, sign- or zero-extended.
  - Store -> merge the low (1 << size) bytes of wdata over the captured data, place the result on mem_data_in -> WR_PULSE.
- WR_PULSE: mem_write = 1 for exactly one cycle, with address and data valid in that same cycle -> WR_HOLD.
- WR_HOLD: mem_write = 0; mem_address and mem_data_in held for WR_LAT cycles -> RESP.
- RESP: resp_valid = 1 for one cycle, resp_rdata/resp_fault valid in that cycle -> IDLE. No backpressure on the response.
- Throughput: req_ready is 0 in every state except IDLE; req_valid while busy is ignored.
- Outside their active states, mem_address and mem_data_in are 0, and mem_read and mem_write are never both 1.
- Latency from accept to resp_valid:
  - Load: RD_LAT+1.
  - Dword store: WR_LAT+2.
  - Sub-dword store: RD_LAT+WR_LAT+2.
  - Fault: 1.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined: an accepted request whose addr is not a multiple of (1 << size) also faults, with no memory access.
- Undefined: any alignment is legal; only the range check applies.

Decomposition:
- Shared package mem_ctrl_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_DWORD;
  - the state enum;
  - function size_bytes(size).
- One combinational sub-module, mem_lane_merge, performs:
  - load extraction and extension (size, signed);
  - store merge (old data, new data, size).

Test Plan:
- Memory preloaded with byte[i] = i. Dword load at 0 -> resp_rdata 0x0706050403020100 after RD_LAT+1 cycles; mem_write stays 0 throughout.
- Half store 0xBEEF at 16, then dword load at 16 -> 0x17161514_1312BEEF; bytes 18..23 unchanged; exactly one mem_write pulse.
- Byte store 0x80 at 40, then signed byte load at 40 -> 0xFFFFFFFFFFFFFF80; unsigned byte load at 40 -> 0x80.
- Dword load at 121 (and at 0xFFFF_FFFF_FFFF_FFF8) -> resp_fault 1, resp_rdata 0, mem_read never asserted, resp one cycle after accept.
- Assert rst_n low during WR_HOLD -> all outputs 0 asynchronously, no resp_valid, req_ready 1 after release; the next load completes normally.
- Half load at 3 -> fault with MEM_ALIGN_CHECK_EN; returns 0x0403 without it.
